mem_stage_dmem_ctrl: RTL and testbench
======================================

Name: mem_stage_dmem_ctrl

Overview:
MEM-stage data-memory controller, directly upstream of the MEM/WB pipeline register. It takes the EX/MEM-registered address, store data and control, and runs a req/ack transaction on a variable-latency data-memory bus. It performs byte/halfword/word lane alignment and load sign/zero extension, then presents MEM_Data_mem_out to MEM/WB. It stalls the pipeline while a transaction is outstanding and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ without dmem_ack before abort (1..2^CNT_W-1)
CNT_W, 8, width of timeout counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
MEM_ALU_out  in  32  effective address from EX/MEM
MEM_write_data  in  32  store data (rt) from EX/MEM
MEM_MemRead  in  1  load in MEM stage
MEM_MemWrite  in  1  store in MEM stage
MEM_mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
MEM_load_unsigned  in  1  1 = zero-extend (lbu/lhu), 0 = sign-extend
MEM_Data_mem_out  out  32  aligned/extended load data to MEM/WB
MEM_stall  out  1  hold IF/ID/EX/MEM registers, bubble into MEM/WB
mem_misaligned  out  1  one-cycle misaligned-access flag
mem_bus_err  out  1  one-cycle timeout flag
dmem_req  out  1  bus request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  32  word address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  one-cycle completion; rdata valid same cycle
dmem_rdata  in  32  raw read word

Behaviour:
- States: IDLE, REQ, DONE. Reset (async, rst_n=0): state IDLE; dmem_req/dmem_we 0; dmem_addr/dmem_wdata/dmem_be 0; data register 0; counter 0; mem_bus_err 0. Takes effect immediately, including mid-REQ (request dropped, no completion reported).
- access = MEM_MemRead | MEM_MemWrite; if both high, treat as read.
- misaligned (combinational): word and addr[1:0]!=0, or half and addr[0]!=0.
- IDLE: no access -> MEM_stall=0, MEM_Data_mem_out=0. Aligned access -> MEM_stall=1 (combinational); on the edge, latch dmem_addr/we/be/wdata, set dmem_req=1, load size/unsigned/addr[1:0], go REQ. Misaligned access -> no request, mem_misaligned=1 this cycle, MEM_stall=0, data out 0.
- REQ: MEM_stall=1; bus outputs stable. Counter increments each cycle. dmem_ack=1 -> capture extended rdata, dmem_req=0, go DONE. Ack on the same cycle as counter==TIMEOUT_CYCLES-1 -> ack wins. Counter reaches TIMEOUT_CYCLES-1 without ack -> dmem_req=0, data 0, mem_bus_err=1 for the DONE cycle, go DONE.
- DONE: MEM_stall=0; MEM_Data_mem_out = captured register (held stable); the edge advances the instruction into MEM/WB; go IDLE, counter cleared.
- dmem_ack outside REQ is ignored.
- Minimum memory-op latency: 3 cycles (IDLE, REQ with immediate ack, DONE). Non-memory instructions: 0 stall cycles.
- Byte lanes, with k=addr[1:0]: byte be=1<<k, wdata={4{wd[7:0]}}; half be=0011 (k=0) or 1100 (k=2), wdata={2{wd[15:0]}}; word be=1111, wdata=wd. Writes return data 0.
- Load extract: byte = rdata[8k+7:8k]; half = rdata[16(k/2)+15:16(k/2)]; extend per MEM_load_unsigned.
- MEM_stall is the only pipeline-hold signal; upstream inputs are assumed stable while MEM_stall=1.

Decomposition:
- Package mips_mem_pkg: SZ_BYTE/SZ_HALF/SZ_WORD encodings, state encoding localparams (IDLE/REQ/DONE).
- One combinational sub-module mem_lane_align: computes be, wdata replication, load extract/extend, and misaligned. Everything else (FSM, counter, registers) stays in the top.

Test Plan:
- Word load, addr 0x0000_0010, ack after 2 REQ cycles, rdata 0x1234_5678 -> dmem_addr 0x10, be 1111, MEM_stall high 3 cycles, DONE outputs 0x1234_5678.
- lb at addr 0x13, rdata 0x80AB_CDEF -> be 1000, out 0xFFFF_FF80; lbu at the same address -> 0x0000_0080.
- sh at addr 0x22, wd 0xAAAA_BEEF -> dmem_we 1, be 1100, wdata 0xBEEF_BEEF, single ack -> out 0.
- lw at addr 0x06 -> mem_misaligned one cycle, dmem_req never asserted, MEM_stall 0.
- No ack, TIMEOUT_CYCLES=4 -> dmem_req high 4 cycles then low, mem_bus_err pulse, out 0, back to IDLE.
- rst_n low during REQ -> dmem_req 0 immediately, MEM_stall 0, state IDLE; a stale ack is ignored.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage data-memory controller.
// Contents: access-size codes, FSM state codes, data-path widths and a
// size-decode helper.
package mips_mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // MEM_mem_size encodings; 2'b11 is decoded as a word access
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Controller state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Both SZ_WORD and the reserved 2'b11 select a full word
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data-memory port.
// Store side: byte enables, lane-replicated write data and alignment check
//   from the live access size / low address bits.
// Load side: extracts the addressed byte/halfword from the raw bus word and
//   sign- or zero-extends it, using the size/offset captured at issue.
// Ports:
//   st_size_i, st_addr_lo_i, st_wdata_i  - store-side size, addr[1:0], data
//   ld_size_i, ld_addr_lo_i, ld_unsigned_i, ld_rdata_i - load-side controls, raw word
//   be_o, wdata_o, misaligned_o          - store-side results
//   ld_data_o                            - aligned/extended load data
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]      st_size_i,
  input  logic [1:0]      st_addr_lo_i,
  input  logic [XLEN-1:0] st_wdata_i,
  input  logic [1:0]      ld_size_i,
  input  logic [1:0]      ld_addr_lo_i,
  input  logic            ld_unsigned_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store lanes: replicate the narrow datum so any lane select picks it up
  always_comb begin
    be_o         = '0;
    wdata_o      = st_wdata_i;
    misaligned_o = 1'b0;
    if (is_word(st_size_i)) begin
      be_o         = 4'b1111;
      wdata_o      = st_wdata_i;
      misaligned_o = (st_addr_lo_i != 2'b00);
    end else if (st_size_i == SZ_HALF) begin
      be_o         = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
      wdata_o      = {2{st_wdata_i[15:0]}};
      misaligned_o = st_addr_lo_i[0];
    end else begin
      be_o         = 4'(4'b0001 << st_addr_lo_i);
      wdata_o      = {4{st_wdata_i[7:0]}};
    end
  end

  // Load lane select
  always_comb begin
    ld_byte = ld_rdata_i[7:0];
    case (ld_addr_lo_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
  end

  // Load extension
  always_comb begin
    ld_data_o = ld_rdata_i;
    if (is_word(ld_size_i)) begin
      ld_data_o = ld_rdata_i;
    end else if (ld_size_i == SZ_HALF) begin
      ld_data_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
    end else begin
      ld_data_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
    end
  end

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller feeding the MEM/WB register.
// Issues one req/ack bus transaction per aligned load/store, stalls the
// pipeline while it is outstanding, aborts after TIMEOUT_CYCLES REQ cycles
// without ack, and flags misaligned accesses without touching the bus.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   MEM_ALU_out, MEM_write_data     - address and store data from EX/MEM
//   MEM_MemRead, MEM_MemWrite       - access type (both high = read)
//   MEM_mem_size, MEM_load_unsigned - access size, load extension mode
//   MEM_Data_mem_out                - load result to MEM/WB (valid in DONE)
//   MEM_stall                       - pipeline hold
//   mem_misaligned, mem_bus_err     - one-cycle fault flags
//   dmem_req/we/addr/wdata/be       - registered bus request
//   dmem_ack, dmem_rdata            - bus completion and read word
module mem_stage_dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] MEM_ALU_out,
  input  logic [XLEN-1:0] MEM_write_data,
  input  logic            MEM_MemRead,
  input  logic            MEM_MemWrite,
  input  logic [1:0]      MEM_mem_size,
  input  logic            MEM_load_unsigned,
  output logic [XLEN-1:0] MEM_Data_mem_out,
  output logic            MEM_stall,
  output logic            mem_misaligned,
  output logic            mem_bus_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [BE_W-1:0] dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      lo_q, lo_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic            access_c;
  logic            write_c;
  logic            lane_mis_c;
  logic            mis_c;
  logic            start_c;
  logic            timeout_c;
  logic [BE_W-1:0] st_be_c;
  logic [XLEN-1:0] st_wdata_c;
  logic [XLEN-1:0] ld_data_c;

  // Read has priority when both strobes are set
  assign access_c  = MEM_MemRead | MEM_MemWrite;
  assign write_c   = MEM_MemWrite & ~MEM_MemRead;
  assign mis_c     = access_c & lane_mis_c;
  assign start_c   = (state_q == ST_IDLE) & access_c & ~lane_mis_c;
  // Ack on the final counted cycle still completes normally
  assign timeout_c = (state_q == ST_REQ) & ~dmem_ack & (cnt_q == CNT_LAST);

  mem_lane_align u_lane (
    .st_size_i     (MEM_mem_size),
    .st_addr_lo_i  (MEM_ALU_out[1:0]),
    .st_wdata_i    (MEM_write_data),
    .ld_size_i     (size_q),
    .ld_addr_lo_i  (lo_q),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (dmem_rdata),
    .be_o          (st_be_c),
    .wdata_o       (st_wdata_c),
    .misaligned_o  (lane_mis_c),
    .ld_data_o     (ld_data_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_c) state_d = ST_REQ;
      ST_REQ:  if (dmem_ack || timeout_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipeline-facing outputs
  always_comb begin
    MEM_stall        = 1'b0;
    MEM_Data_mem_out = '0;
    mem_misaligned   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        MEM_stall      = start_c;
        mem_misaligned = mis_c;
      end
      ST_REQ:  MEM_stall = 1'b1;
      ST_DONE: MEM_Data_mem_out = data_q;
      default: ;
    endcase
  end

  // Bus request, capture and timeout bookkeeping
  always_comb begin
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lo_d    = lo_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_c) begin
          req_d   = 1'b1;
          we_d    = write_c;
          addr_d  = {MEM_ALU_out[XLEN-1:2], 2'b00};
          wdata_d = st_wdata_c;
          be_d    = st_be_c;
          size_d  = MEM_mem_size;
          uns_d   = MEM_load_unsigned;
          lo_d    = MEM_ALU_out[1:0];
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          req_d  = 1'b0;
          data_d = we_q ? '0 : ld_data_c;
        end else if (timeout_c) begin
          req_d  = 1'b0;
          data_d = '0;
          err_d  = 1'b1;
        end
      end
      ST_DONE: cnt_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= SZ_WORD;
      uns_q   <= 1'b0;
      lo_q    <= 2'b00;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign mem_bus_err = err_q;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Bench for mem_stage_dmem_ctrl: transaction-level expected timeline per
// access, one negedge compare process, plus literal checks on directed ops.
module tb_mem_stage_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_out, wr_data, rdata;
  logic        mem_rd, mem_wr, ld_uns, ack;
  logic [1:0]  msize;
  logic [31:0] dout, d_addr, d_wdata;
  logic        stall, mis, berr, d_req, d_we;
  logic [3:0]  d_be;

  mem_stage_dmem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_ALU_out(alu_out), .MEM_write_data(wr_data),
    .MEM_MemRead(mem_rd), .MEM_MemWrite(mem_wr),
    .MEM_mem_size(msize), .MEM_load_unsigned(ld_uns),
    .MEM_Data_mem_out(dout), .MEM_stall(stall),
    .mem_misaligned(mis), .mem_bus_err(berr),
    .dmem_req(d_req), .dmem_we(d_we), .dmem_addr(d_addr),
    .dmem_wdata(d_wdata), .dmem_be(d_be),
    .dmem_ack(ack), .dmem_rdata(rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected outputs for the current cycle
  logic        chk_en, exp_stall, exp_req, exp_mis, exp_err, exp_bus, exp_we;
  logic [31:0] exp_out, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  // per-op observations used by literal checks
  int          n_stall, n_req, n_err, n_mis;
  logic [31:0] last_out, last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("req",   32'(d_req), 32'(exp_req));
      chk("out",   dout,       exp_out);
      chk("mis",   32'(mis),   32'(exp_mis));
      chk("err",   32'(berr),  32'(exp_err));
      if (exp_bus) begin
        chk("we",    32'(d_we), 32'(exp_we));
        chk("addr",  d_addr,    exp_addr);
        chk("be",    32'(d_be), 32'(exp_be));
        chk("wdata", d_wdata,   exp_wdata);
      end
    end
    if (stall) n_stall++;
    if (berr)  n_err++;
    if (mis)   n_mis++;
    if (d_req) begin
      n_req++;
      last_addr = d_addr; last_be = d_be; last_wdata = d_wdata; last_we = d_we;
    end
    last_out = dout;
  end

  // ---- reference model (spec arithmetic) ----
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
    int unsigned k = a % 4;
    logic [31:0] v;
    if (sz >= 2) return rd;
    if (sz == 1) begin
      v = (rd >> (16 * (k / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = (rd >> (8 * k)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    int unsigned k = a % 4;
    if (sz >= 2) return 4'hF;
    if (sz == 1) return 4'(3 << k);
    return 4'(1 << k);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz >= 2) return wd;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return (wd & 32'hFF) * 32'h0101_0101;
  endfunction

  task automatic end_cycle();
    @(negedge clk); #1;
  endtask

  task automatic idle_exp();
    exp_stall = 0; exp_req = 0; exp_out = 0; exp_mis = 0; exp_err = 0; exp_bus = 0;
  endtask

  // One instruction through MEM: drive it and predict every cycle it occupies
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rword, input int dly);
    logic acc, we, misx;
    int   r;
    acc  = rd | wr;
    we   = wr & !rd;
    misx = acc && ((sz >= 2) ? (a % 4 != 0) : (sz == 1) ? (a % 2 != 0) : 1'b0);
    n_stall = 0; n_req = 0; n_err = 0; n_mis = 0;
    @(posedge clk); #1;
    mem_rd = rd; mem_wr = wr; msize = sz; ld_uns = uns; alu_out = a; wr_data = wd;
    ack = ($urandom % 4 == 0); rdata = $urandom;
    idle_exp();
    exp_stall = acc && !misx; exp_mis = misx;
    end_cycle();
    if (!acc || misx) return;
    r = (dly < TO) ? dly + 1 : TO;
    for (int i = 0; i < r; i++) begin
      @(posedge clk); #1;
      ack   = (i == dly);
      rdata = (i == dly) ? rword : $urandom;
      idle_exp();
      exp_stall = 1; exp_req = 1; exp_bus = 1;
      exp_we = we; exp_addr = a & 32'hFFFF_FFFC; exp_be = m_be(a, sz); exp_wdata = m_wdata(wd, sz);
      end_cycle();
    end
    @(posedge clk); #1;
    ack = ($urandom % 2 == 0); rdata = $urandom;
    idle_exp();
    exp_out = (dly < TO && !we) ? m_load(rword, a, sz, uns) : 32'h0;
    exp_err = (dly >= TO);
    end_cycle();
  endtask

  initial begin
    rst_n = 0; alu_out = 0; wr_data = 0; rdata = 0; mem_rd = 0; mem_wr = 0;
    ld_uns = 0; ack = 0; msize = 0;
    idle_exp(); exp_bus = 1; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
    chk_en = 1;
    #23 rst_n = 1;
    end_cycle();

    // word load, ack on second REQ cycle
    do_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234_5678, 1);
    chk("lw_out", last_out, 32'h1234_5678);
    chk("lw_addr", last_addr, 32'h10);
    chk("lw_be", 32'(last_be), 32'hF);
    chk("lw_stall_cycles", n_stall, 3);
    chk("lw_req_cycles", n_req, 2);

    // signed / unsigned byte loads
    do_op(1, 0, 2'b00, 0, 32'h13, 32'h0, 32'h80AB_CDEF, 0);
    chk("lb_out", last_out, 32'hFFFF_FF80);
    chk("lb_be", 32'(last_be), 32'h8);
    do_op(1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h80AB_CDEF, 0);
    chk("lbu_out", last_out, 32'h0000_0080);

    // halfword store
    do_op(0, 1, 2'b01, 0, 32'h22, 32'hAAAA_BEEF, 32'hDEAD_0000, 0);
    chk("sh_we", 32'(last_we), 32'h1);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    chk("sh_out", last_out, 32'h0);

    // misaligned word load
    do_op(1, 0, 2'b10, 0, 32'h06, 32'h0, 32'h0, 0);
    chk("mis_cycles", n_mis, 1);
    chk("mis_req", n_req, 0);
    chk("mis_stall", n_stall, 0);

    // timeout
    do_op(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h5555_AAAA, 20);
    chk("to_req_cycles", n_req, TO);
    chk("to_err_cycles", n_err, 1);
    chk("to_out", last_out, 32'h0);

    // non-memory instruction
    do_op(0, 0, 2'b10, 0, 32'h44, 32'h0, 32'h0, 0);
    chk("nop_stall", n_stall, 0);

    // reset asserted mid-REQ
    @(posedge clk); #1;
    mem_rd = 1; mem_wr = 0; msize = 2'b10; alu_out = 32'h80; wr_data = 0; ack = 0;
    idle_exp(); exp_stall = 1;
    end_cycle();
    @(posedge clk); #1;
    idle_exp(); exp_stall = 1; exp_req = 1; exp_bus = 1;
    exp_we = 0; exp_addr = 32'h80; exp_be = 4'hF; exp_wdata = 32'h0;
    end_cycle();
    rst_n = 0; mem_rd = 0;
    #1;
    chk("rst_req_now", 32'(d_req), 32'h0);
    chk("rst_stall_now", 32'(stall), 32'h0);
    idle_exp(); exp_bus = 1; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
    end_cycle();
    @(posedge clk); #1;
    rst_n = 1; ack = 1; rdata = 32'hCAFE_F00D;
    end_cycle();
    ack = 0;
    do_op(1, 0, 2'b01, 1, 32'h86, 32'h0, 32'h9876_5432, 0);
    chk("post_rst_lhu", last_out, 32'h0000_9876);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [1:0] kind;
      int dly;
      kind = 2'($urandom);
      dly  = ($urandom % 8 == 0) ? 6 : int'($urandom_range(0, 3));
      do_op(kind[0], kind[1], 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, dly);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
